// File: rtl/or32_split_pkg.sv
// or32_split_pkg: shared types and constants for the or32_split bit-splitter.
// Optional feature macro used by the slice: OR32_SPLIT_INDEX_EN (adds out_index).
package or32_split_pkg;

    // Two-state control: waiting for a word, or emitting its one-hot beats.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 32;

    // Width of the binary bit-position encoding for a WIDTH-bit word.
    function automatic int index_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/or32_split_lsb_isolate.sv
// lsb_isolate: combinational lowest-set-bit extractor for the or32_split remainder.
// Produces the isolated bit, the "this is the final bit" flag and, when
// OR32_SPLIT_INDEX_EN is defined, the binary position of the isolated bit.
module lsb_isolate
    import or32_split_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             zero_flag,
    output logic [WIDTH-1:0] lsb,
`ifdef OR32_SPLIT_INDEX_EN
    output logic [index_width(WIDTH)-1:0] index,
`endif
    output logic             last
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Two's-complement trick isolates the lowest set bit; a zero word emits a
    // single all-zero beat that is always the last one.
    always_comb begin
        lsb  = zero_flag ? '0 : (rem & (~rem + ONE));
        last = zero_flag | ((rem & (rem - ONE)) == '0);
    end

`ifdef OR32_SPLIT_INDEX_EN
    localparam int IW = index_width(WIDTH);

    // One-hot to binary encoder; an all-zero beat encodes as position 0.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (lsb[i]) begin
                index = index | IW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/or32_split.sv
// or32_split: splits an accepted word into one-hot beats, lowest set bit first.
// A zero word yields one all-zero beat flagged last. The next word can load on
// the same edge that the last beat of the current word is taken, so words held
// back-to-back on the input stream without bubbles.
// Optional feature macro: OR32_SPLIT_INDEX_EN (adds the out_index port).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits on ready, out_valid/out_bit/out_last/out_index
// hold steady while out_valid=1 and out_ready=0, and in_ready in EMIT follows
// out_last & out_ready combinationally.
module or32_split
    import or32_split_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bit,
    output logic             out_last,
`ifdef OR32_SPLIT_INDEX_EN
    output logic [index_width(WIDTH)-1:0] out_index,
`endif
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic             zero_flag;
    logic             zero_nxt;

    logic [WIDTH-1:0] iso_bit;
    logic             iso_last;
    logic             emit;
    logic             in_fire;
    logic             out_fire;
`ifdef OR32_SPLIT_INDEX_EN
    logic [index_width(WIDTH)-1:0] iso_index;
`endif

    lsb_isolate #(
        .WIDTH(WIDTH)
    ) u_lsb_isolate (
        .rem       (rem),
        .zero_flag (zero_flag),
        .lsb       (iso_bit),
`ifdef OR32_SPLIT_INDEX_EN
        .index     (iso_index),
`endif
        .last      (iso_last)
    );

    // State and remainder registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= S_IDLE;
            rem       <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem       <= rem_nxt;
            zero_flag <= zero_nxt;
        end
    end

    // Next state: load on accept, clear taken bits, chain or retire on the last beat.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        zero_nxt  = zero_flag;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        case (state)
            S_IDLE: begin
                if (in_fire) begin
                    state_nxt = S_EMIT;
                    rem_nxt   = in_word;
                    zero_nxt  = (in_word == '0);
                end
            end
            S_EMIT: begin
                if (out_fire) begin
                    if (!out_last) begin
                        rem_nxt = rem & ~out_bit;
                    end else if (in_fire) begin
                        rem_nxt  = in_word;
                        zero_nxt = (in_word == '0);
                    end else begin
                        state_nxt = S_IDLE;
                        rem_nxt   = '0;
                        zero_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs: everything is forced quiet while resetn is low.
    always_comb begin
        emit      = resetn & (state == S_EMIT);
        out_valid = emit;
        busy      = emit;
        out_bit   = emit ? iso_bit : '0;
        out_last  = emit & iso_last;
        in_ready  = resetn & ((state == S_IDLE) | (iso_last & out_ready));
`ifdef OR32_SPLIT_INDEX_EN
        out_index = emit ? iso_index : '0;
`endif
    end

endmodule

// File: tb/tb_or32_split.sv
// tb_or32_split: self-checking bench for or32_split (directed scenarios plus a
// randomized stream checked against a bit-position reference model).
`timescale 1ns/1ps
module tb_or32_split;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_word = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_bit;
    logic         out_last;
    logic         busy;
`ifdef OR32_SPLIT_INDEX_EN
    logic [4:0]   out_index;
`endif

    int checks = 0;
    int passed = 0;

    // Expected beats: {last, one-hot bit}, plus the expected bit position.
    logic [W:0]   exp_q[$];
    int           idx_q[$];

    or32_split #(.WIDTH(W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
`ifdef OR32_SPLIT_INDEX_EN
        .out_index (out_index),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Reference: list the set-bit positions in ascending order; each becomes a
    // one-hot beat, the final one flagged last; an empty list gives one zero beat.
    function automatic void model_split(input logic [W-1:0] word);
        int pos[$];
        for (int i = 0; i < W; i++) begin
            if (word[i]) pos.push_back(i);
        end
        if (pos.size() == 0) begin
            exp_q.push_back({1'b1, {W{1'b0}}});
            idx_q.push_back(0);
        end else begin
            for (int j = 0; j < pos.size(); j++) begin
                exp_q.push_back({(j == pos.size() - 1), (W'(1) << pos[j])});
                idx_q.push_back(pos[j]);
            end
        end
    endfunction

    function automatic logic [W-1:0] gen_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'(1) << $urandom_range(0, W - 1);
            2:       return $urandom;
            default: return $urandom & $urandom & $urandom;
        endcase
    endfunction

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b1; in_word = 32'hA5A5_0001; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (out_bit !== '0) $display("FAIL reset_out_bit: got %h expected 0", out_bit); else passed++;
        checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
`ifdef OR32_SPLIT_INDEX_EN
        checks++; if (out_index !== 5'd0) $display("FAIL reset_out_index: got %0d expected 0", out_index); else passed++;
`endif
        @(posedge clock); #1;
        resetn = 1'b1; in_valid = 1'b0;
        @(negedge clock);
        checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_sparse();
        logic [W-1:0] exp_b[3];
        int           exp_i[3];
        exp_b[0] = 32'h0000_0001; exp_b[1] = 32'h0000_0010; exp_b[2] = 32'h8000_0000;
        exp_i[0] = 0; exp_i[1] = 4; exp_i[2] = 31;
        @(posedge clock); #1;
        in_valid = 1'b1; in_word = 32'h8000_0011; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (out_valid !== 1'b1) $display("FAIL sparse_valid[%0d]: got %b expected 1", k, out_valid); else passed++;
            checks++; if (out_bit !== exp_b[k]) $display("FAIL sparse_bit[%0d]: got %h expected %h", k, out_bit, exp_b[k]); else passed++;
            checks++; if (out_last !== (k == 2)) $display("FAIL sparse_last[%0d]: got %b expected %b", k, out_last, (k == 2)); else passed++;
`ifdef OR32_SPLIT_INDEX_EN
            checks++; if (int'(out_index) != exp_i[k]) $display("FAIL sparse_index[%0d]: got %0d expected %0d", k, out_index, exp_i[k]); else passed++;
`endif
            @(posedge clock); #1;
        end
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL sparse_done_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_zero();
        @(posedge clock); #1;
        in_valid = 1'b1; in_word = '0; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b1) $display("FAIL zero_valid: got %b expected 1", out_valid); else passed++;
        checks++; if (out_bit !== '0) $display("FAIL zero_bit: got %h expected 0", out_bit); else passed++;
        checks++; if (out_last !== 1'b1) $display("FAIL zero_last: got %b expected 1", out_last); else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL zero_after_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL zero_after_ready: got %b expected 1", in_ready); else passed++;
    endtask

    task automatic test_full_stall();
        int         k = 0;
        int         cyc = 0;
        logic       stalled = 1'b0;
        logic [W:0] held = '0;
        @(posedge clock); #1;
        in_valid = 1'b1; in_word = '1; out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        while (k < 32 && cyc < 200) begin
            out_ready = ((cyc % 2) == 1);
            @(negedge clock);
            checks++; if (out_valid !== 1'b1) $display("FAIL full_valid[%0d]: got %b expected 1", k, out_valid); else passed++;
            checks++;
            if ({out_last, out_bit} !== {(k == 31), (W'(1) << k)})
                $display("FAIL full_beat[%0d]: got last=%b bit=%h expected last=%b bit=%h", k, out_last, out_bit, (k == 31), W'(1) << k);
            else passed++;
            if (stalled) begin
                checks++; if ({out_last, out_bit} !== held) $display("FAIL full_hold[%0d]: got %h expected %h", k, {out_last, out_bit}, held); else passed++;
            end
            held = {out_last, out_bit};
            stalled = !out_ready;
            if (out_ready) k++;
            cyc++;
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        checks++; if (k != 32) $display("FAIL full_count: got %0d expected 32", k); else passed++;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL full_done_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        @(posedge clock); #1;
        in_valid = 1'b1; in_word = 32'h0000_0006; out_ready = 1'b1;
        @(posedge clock); #1;
        in_word = 32'h0000_0001;
        @(negedge clock);
        checks++; if ({out_valid, out_last, out_bit} !== {2'b10, 32'h2}) $display("FAIL b2b_beat0: got v=%b l=%b bit=%h expected v=1 l=0 bit=2", out_valid, out_last, out_bit); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL b2b_ready0: got %b expected 0", in_ready); else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if ({out_valid, out_last, out_bit} !== {2'b11, 32'h4}) $display("FAIL b2b_beat1: got v=%b l=%b bit=%h expected v=1 l=1 bit=4", out_valid, out_last, out_bit); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1: got %b expected 1", in_ready); else passed++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if ({out_valid, out_last, out_bit} !== {2'b11, 32'h1}) $display("FAIL b2b_beat2: got v=%b l=%b bit=%h expected v=1 l=1 bit=1", out_valid, out_last, out_bit); else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_done_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        in_valid = 1'b1; in_word = 32'h0000_00F0; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if (out_bit !== 32'h10) $display("FAIL rmid_beat0: got %h expected 10", out_bit); else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (out_bit !== 32'h20) $display("FAIL rmid_beat1: got %h expected 20", out_bit); else passed++;
        @(posedge clock); #1;
        resetn = 1'b0;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_rst_valid: got %b expected 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rmid_rst_ready: got %b expected 0", in_ready); else passed++;
        @(posedge clock); #1;
        resetn = 1'b1; in_valid = 1'b1; in_word = 32'h0000_0003;
        @(negedge clock);
        checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rmid_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); else passed++;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++; if ({out_valid, out_last, out_bit} !== {2'b10, 32'h1}) $display("FAIL rmid_new0: got v=%b l=%b bit=%h expected v=1 l=0 bit=1", out_valid, out_last, out_bit); else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if ({out_valid, out_last, out_bit} !== {2'b11, 32'h2}) $display("FAIL rmid_new1: got v=%b l=%b bit=%h expected v=1 l=1 bit=2", out_valid, out_last, out_bit); else passed++;
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_done_valid: got %b expected 0", out_valid); else passed++;
    endtask

    task automatic test_random();
        int   words_left = 60;
        int   cycles = 0;
        logic accepted = 1'b0;
        exp_q.delete();
        idx_q.delete();
        while ((words_left > 0 || exp_q.size() > 0 || in_valid) && cycles < 4000) begin
            @(posedge clock); #1;
            cycles++;
            if (accepted) in_valid = 1'b0;
            accepted = 1'b0;
            if (!in_valid && words_left > 0 && $urandom_range(0, 3) != 0) begin
                in_word = gen_word();
                in_valid = 1'b1;
                words_left--;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            checks++; if (busy !== out_valid) $display("FAIL rand_busy: got %b expected %b", busy, out_valid); else passed++;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra_beat: got bit=%h expected no beat", out_bit);
                end else begin
                    if ({out_last, out_bit} !== exp_q[0])
                        $display("FAIL rand_beat: got last=%b bit=%h expected last=%b bit=%h", out_last, out_bit, exp_q[0][W], exp_q[0][W-1:0]);
                    else passed++;
`ifdef OR32_SPLIT_INDEX_EN
                    checks++; if (int'(out_index) != idx_q[0]) $display("FAIL rand_index: got %0d expected %0d", out_index, idx_q[0]); else passed++;
`endif
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(idx_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                model_split(in_word);
                accepted = 1'b1;
            end
        end
        in_valid = 1'b0;
        checks++; if (cycles >= 4000) $display("FAIL rand_timeout: got %0d cycles expected under 4000", cycles); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL rand_leftover: got %0d pending beats expected 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_sparse();
        test_zero();
        test_full_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
